// File: rtl/toggle_gen_bank.sv
// Bank of CH independent programmable toggle generators. Each channel divides
// the clock by its divide register and toggles its output on every expiry.
module toggle_gen_bank #(
  parameter int CH    = 4,
  parameter int CNT_W = 16,
  parameter int CH_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_oneshot,
  input  logic [CH-1:0]    start,
  input  logic [CH-1:0]    stop,
  input  logic [CH-1:0]    toggle_in,
  output logic [CH-1:0]    out,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    busy
);

  for (genvar g = 0; g < CH; g++) begin : g_chan
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_oneshot;
    logic             r_run;
    logic             r_out;
    logic             r_tick;
    logic             w_cfgHit;
    logic             w_expire;

    // Addresses >= CH never match any generated channel, so they are ignored.
    assign w_cfgHit = cfg_we && (cfg_ch == CH_W'(g));
    assign w_expire = r_run && (r_cnt == '0) && !start[g] && !stop[g];

    // A direct toggle and an expiry each invert out, so XOR makes a
    // coincident pair cancel while tick and reload still happen.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_div     <= '0;
        r_cnt     <= '0;
        r_oneshot <= 1'b0;
        r_run     <= 1'b0;
        r_out     <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        if (w_cfgHit) begin
          r_div     <= cfg_div;
          r_oneshot <= cfg_oneshot;
        end
        r_tick <= w_expire;
        r_out  <= r_out ^ toggle_in[g] ^ w_expire;
        if (stop[g]) begin
          r_run <= 1'b0;
        end else if (start[g]) begin
          r_run <= 1'b1;
          r_cnt <= r_div;
        end else if (w_expire) begin
          r_cnt <= r_div;
          if (r_oneshot) begin
            r_run <= 1'b0;
          end
        end else if (r_run) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end

    assign out[g]  = r_out;
    assign tick[g] = r_tick;
    assign busy[g] = r_run;
  end

endmodule

// File: tb/tb_toggle_gen_bank.sv
// Directed bench for toggle_gen_bank: a vector table for the basic continuous
// divide, plus hand-written multi-cycle sequences for the corner cases.
module tb_toggle_gen_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_oneshot;
  logic [3:0]  start, stop, toggle_in;
  logic [3:0]  out, tick, busy;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] div;
    logic        os;
    logic [3:0]  st;
    logic [3:0]  sp;
    logic [3:0]  tg;
    logic [3:0]  eOut;
    logic [3:0]  eTick;
    logic [3:0]  eBusy;
  } vec_t;

  vec_t vecs [15];

  toggle_gen_bank #(.CH(4), .CNT_W(16), .CH_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_oneshot(cfg_oneshot),
    .start      (start),
    .stop       (stop),
    .toggle_in  (toggle_in),
    .out        (out),
    .tick       (tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge pass, then return inputs to idle.
  task automatic applyStimulus(input logic rst, input logic we, input logic [1:0] ch,
                               input logic [15:0] div, input logic os,
                               input logic [3:0] st, input logic [3:0] sp,
                               input logic [3:0] tg);
    reset = rst; cfg_we = we; cfg_ch = ch; cfg_div = div; cfg_oneshot = os;
    start = st; stop = sp; toggle_in = tg;
    @(posedge clk);
    #1;
    reset = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
    start = '0; stop = '0; toggle_in = '0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eOut,
                             input logic [3:0] eTick, input logic [3:0] eBusy);
    compared += 3;
    if (out !== eOut) begin
      mismatched++;
      $display("[TB] FAIL %s out: got %b, expected %b", name, out, eOut);
    end
    if (tick !== eTick) begin
      mismatched++;
      $display("[TB] FAIL %s tick: got %b, expected %b", name, tick, eTick);
    end
    if (busy !== eBusy) begin
      mismatched++;
      $display("[TB] FAIL %s busy: got %b, expected %b", name, busy, eBusy);
    end
  endtask

  initial begin
    logic [9:0] seqOut;
    logic [9:0] seqTick;

    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
    start = '0; stop = '0; toggle_in = '0;

    // ch0 D=3 continuous; ch1 toggled directly while idle
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 16'd3, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h1, 4'h0, 4'h0, 4'b0000, 4'b0000, 4'b0001};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 4'b0001};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 4'b0001};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 4'b0001};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0001, 4'b0001, 4'b0001};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h2, 4'b0011, 4'b0000, 4'b0001};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0011, 4'b0000, 4'b0001};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0011, 4'b0000, 4'b0001};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0010, 4'b0001, 4'b0001};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0010, 4'b0000, 4'b0001};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0010, 4'b0000, 4'b0001};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0010, 4'b0000, 4'b0001};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b0011, 4'b0001, 4'b0001};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].ch, vecs[i].div, vecs[i].os,
                    vecs[i].st, vecs[i].sp, vecs[i].tg);
      checkOutput($sformatf("vec%0d", i), vecs[i].eOut, vecs[i].eTick, vecs[i].eBusy);
    end

    // One-shot on ch1 with D=2: single toggle three edges after start
    applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    checkOutput("oneshotReset", 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'd2, 1'b1, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h2, 4'h0, 4'h0);
    checkOutput("oneshotStart", 4'b0000, 4'b0000, 4'b0010);
    for (int j = 1; j <= 2; j++) begin
      idle();
      checkOutput($sformatf("oneshotCount%0d", j), 4'b0000, 4'b0000, 4'b0010);
    end
    idle();
    checkOutput("oneshotExpire", 4'b0010, 4'b0010, 4'b0000);
    for (int j = 0; j < 20; j++) begin
      idle();
      checkOutput($sformatf("oneshotQuiet%0d", j), 4'b0010, 4'b0000, 4'b0000);
    end

    // ch2 started with no config: D=0 continuous, then toggle_in cancels expiries
    applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h4, 4'h0, 4'h0);
    checkOutput("d0Start", 4'b0000, 4'b0000, 4'b0100);
    idle();
    checkOutput("d0Toggle1", 4'b0100, 4'b0100, 4'b0100);
    idle();
    checkOutput("d0Toggle2", 4'b0000, 4'b0100, 4'b0100);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h4);
      checkOutput($sformatf("d0Frozen%0d", j), 4'b0000, 4'b0100, 4'b0100);
    end
    idle();
    checkOutput("d0Resume", 4'b0100, 4'b0100, 4'b0100);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h4, 4'h0);
    checkOutput("d0StopOverExpiry", 4'b0100, 4'b0000, 4'b0000);

    // ch3: simultaneous start and stop on a running channel
    applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 2'd3, 16'd5, 1'b0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h0, 4'h0);
    checkOutput("ssStart", 4'b0000, 4'b0000, 4'b1000);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h8);
    checkOutput("ssDirectToggle", 4'b1000, 4'b0000, 4'b1000);
    idle();
    checkOutput("ssRunning", 4'b1000, 4'b0000, 4'b1000);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h0);
    checkOutput("ssStartStop", 4'b1000, 4'b0000, 4'b0000);
    for (int j = 0; j < 10; j++) begin
      idle();
      checkOutput($sformatf("ssHeld%0d", j), 4'b1000, 4'b0000, 4'b0000);
    end

    // ch0 D=5 rewritten to D=1 mid-count: current period finishes at D=5
    applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'd5, 1'b0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h1, 4'h0, 4'h0);
    checkOutput("redivStart", 4'b0000, 4'b0000, 4'b0001);
    seqOut  = 10'b1001100000;
    seqTick = 10'b1010100000;
    for (int j = 0; j < 10; j++) begin
      if (j == 1) applyStimulus(1'b0, 1'b1, 2'd0, 16'd1, 1'b0, 4'h0, 4'h0, 4'h0);
      else        idle();
      checkOutput($sformatf("rediv%0d", j + 1), {3'b000, seqOut[j]},
                  {3'b000, seqTick[j]}, 4'b0001);
    end

    // Same-cycle cfg+start loads old D=2; reset lands on the next expiry edge
    applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'd2, 1'b0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'd7, 1'b0, 4'h1, 4'h0, 4'h0);
    checkOutput("oldDivStart", 4'b0000, 4'b0000, 4'b0001);
    for (int j = 1; j <= 10; j++) begin
      idle();
      if (j < 3)       checkOutput($sformatf("oldDiv%0d", j), 4'b0000, 4'b0000, 4'b0001);
      else if (j == 3) checkOutput("oldDivExpire", 4'b0001, 4'b0001, 4'b0001);
      else             checkOutput($sformatf("newDiv%0d", j), 4'b0001, 4'b0000, 4'b0001);
    end
    applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0);
    checkOutput("resetAtExpiry", 4'b0000, 4'b0000, 4'b0000);
    for (int j = 0; j < 12; j++) begin
      idle();
      checkOutput($sformatf("postReset%0d", j), 4'b0000, 4'b0000, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/toggle_gen_bank.md
TOGGLE_GEN_BANK -- requirements
Module: toggle_gen_bank

Interface
REQ-001 Parameter CH, default 4: number of independent toggle channels, range 1..16.
REQ-002 Parameter CNT_W, default 16: width of each channel's divider counter and divide register.
REQ-003 Parameter CH_W, default 2: channel-select width; SHALL equal ceil(log2(CH)), minimum 1.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_we  input  1  write strobe for the divide/mode registers of channel cfg_ch.
REQ-007 cfg_ch  input  CH_W  channel addressed by cfg_we; values >= CH SHALL be ignored.
REQ-008 cfg_div  input  CNT_W  divide value D written on cfg_we.
REQ-009 cfg_oneshot  input  1  mode written on cfg_we: 1 = one-shot, 0 = continuous.
REQ-010 start  input  CH  per-channel start/restart request, sampled each cycle.
REQ-011 stop  input  CH  per-channel stop request, sampled each cycle.
REQ-012 toggle_in  input  CH  per-channel direct toggle request, sampled each cycle.
REQ-013 out  output  CH  registered toggle outputs.
REQ-014 tick  output  CH  registered one-cycle pulse marking a divider expiry.
REQ-015 busy  output  CH  registered; 1 while the channel is running.

Function
REQ-016 Each channel SHALL hold div[CNT_W], oneshot, cnt[CNT_W], run, and out state, all independent of the other channels.
REQ-017 cfg_we SHALL update div and oneshot of the addressed channel at the next edge; if that channel is running, cnt is not disturbed and the new D applies from the next reload.
REQ-018 start[i] with stop[i]=0 SHALL set run=1 and load cnt=div at the next edge; if the channel is already running, it SHALL restart the count. out is unchanged by start.
REQ-019 stop[i] SHALL clear run at the next edge and has priority over start[i] and any expiry in the same cycle. out holds its value.
REQ-020 Expiry SHALL be defined as run=1 and cnt=0 and no start/stop on that channel in the same cycle.
REQ-021 While running without expiry, cnt SHALL decrement by 1 per cycle.
REQ-022 On expiry, the channel SHALL toggle out, assert tick for exactly one cycle (the cycle after the expiry edge), and reload cnt=div.
REQ-023 On expiry in one-shot mode, the channel SHALL additionally clear run, giving exactly one toggle per start.
REQ-024 Timing: with start at edge k and divide value D, out SHALL toggle at edges k+D+1, k+2(D+1), and so on; the out period is 2(D+1) cycles.
REQ-025 D=0 SHALL toggle out every cycle while running; D=2^CNT_W-1 SHALL be supported without overflow.
REQ-026 toggle_in[i] SHALL invert out[i] at the next edge whether or not the channel is running; it does not affect cnt, run, or tick.
REQ-027 If toggle_in and an expiry coincide on the same channel, the two inversions SHALL cancel: out is unchanged, while tick still asserts and cnt still reloads.
REQ-028 busy[i] SHALL equal run[i].
REQ-029 Simultaneous events on different channels SHALL be fully independent, including a cfg_we to channel j in the same cycle as start on channel j; in that case the start loads the old div.

Reset
REQ-030 While reset=1 at an edge, all out, tick, busy, run, cnt, div, and oneshot SHALL become 0; reset has priority over all other inputs.
REQ-031 Reset asserted mid-count SHALL abort the operation with no residual tick or toggle after the reset edge.
REQ-032 After reset, a channel started with no cfg_we SHALL run with D=0 in continuous mode.

Verification
REQ-033 Program ch0 with D=3, continuous, then pulse start[0] at edge k -> out[0] toggles at k+4, k+8, k+12; tick[0] is high for one cycle after each toggle; busy[0]=1 throughout.
REQ-034 Program ch1 with D=2, one-shot, then start -> exactly one toggle at k+3; busy[1] drops with that edge; no further ticks over 20 cycles.
REQ-035 Continuous run with D=0 on ch2, and toggle_in[2]=1 held for 3 cycles -> out[2] frozen for those 3 cycles while tick[2] pulses every cycle.
REQ-036 Assert start[3] and stop[3] in the same cycle on a running channel -> run cleared, out held, no tick.
REQ-037 While ch0 runs with D=5, write D=1 -> current period completes at D=5, subsequent periods use D=1.
REQ-038 Assert reset on the cycle ch0 would expire -> out=0, tick=0, busy=0 after the edge; no later toggles occur.
